// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its conflict monitor:
// FSM encodings, fault cause bit positions and lamp packing helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_FILTER  = 2'd1,
        ST_FAULT   = 2'd2,
        ST_UNUSED  = 2'd3
    } mon_state_t;

    localparam int CONFLICT_A   = 0;
    localparam int CONFLICT_B   = 1;
    localparam int LAMP_FAULT   = 2;
    localparam int PED_CONFLICT = 3;

    localparam int RED    = 0;
    localparam int YLW    = 1;
    localparam int GRN    = 2;
    localparam int STRIDE = 3;

    // One approach's {grn,ylw,red} aspect: traffic may move on green or yellow.
    function automatic logic moving(input logic [2:0] aspect);
        return aspect[GRN] | aspect[YLW];
    endfunction

    // Exactly one lamp must be lit; dark or multiple lamps are both unsafe.
    function automatic logic bad_aspect(input logic [2:0] aspect);
        return !$onehot(aspect);
    endfunction

endpackage

// File: rtl/cycle_filter.sv
// Persistence counter: met is high in the cycle that completes N consecutive
// cycles of 'in' (and stays high while 'in' holds); the count saturates at N.
module cycle_filter #(
    parameter int N = 1
) (
    input  logic clk_50_mhz,
    input  logic reset,
    input  logic clear,
    input  logic in,
    output logic met
);

    localparam int W = $clog2(N) + 1;

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !in) begin
            count <= '0;
        end else if (count != W'(N)) begin
            count <= count + 1'b1;
        end
    end

    // Counts the current cycle too, so a decision can be taken on the same edge.
    assign met = in && !clear && (count >= W'(N - 1));

endmodule

// File: rtl/conflict_monitor.sv
// Output-side safety checker for both intersections: filters unsafe lamp
// combinations, latches a sticky cause code and drives all-red flash until cleared.
module conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FILTER_CYCLES = 50000,
    parameter int FLASH_HALF    = 25000000,
    parameter int CLEAR_HOLD    = 50000
) (
    input  logic       clk_50_mhz,
    input  logic       reset,
    input  logic [5:0] lamps_a,
    input  logic [5:0] lamps_b,
    input  logic [1:0] walk_a,
    input  logic [1:0] walk_b,
    input  logic       monitor_en,
    input  logic       fault_clear,
    output logic       fault,
    output logic [3:0] fault_code,
    output logic       flash_red,
    output logic [1:0] state_dbg
);

    localparam int FW = $clog2(FLASH_HALF) + 1;

    logic [5:0]  lamps_a_q, lamps_b_q;
    logic [1:0]  walk_a_q, walk_b_q;
    logic        fault_clear_q;
    logic [3:0]  cond;
    logic        cond_any;
    logic        trip, hold_ok, clear_rise;
    logic [3:0]  accum;
    logic [FW-1:0] flash_cnt;
    mon_state_t  state, next_state;

    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            lamps_a_q     <= '0;
            lamps_b_q     <= '0;
            walk_a_q      <= '0;
            walk_b_q      <= '0;
            fault_clear_q <= 1'b0;
        end else begin
            lamps_a_q     <= lamps_a;
            lamps_b_q     <= lamps_b;
            walk_a_q      <= walk_a;
            walk_b_q      <= walk_b;
            fault_clear_q <= fault_clear;
        end
    end

    always_comb begin
        cond               = '0;
        cond[CONFLICT_A]   = moving(lamps_a_q[2:0]) & moving(lamps_a_q[5:3]);
        cond[CONFLICT_B]   = moving(lamps_b_q[2:0]) & moving(lamps_b_q[5:3]);
        cond[LAMP_FAULT]   = bad_aspect(lamps_a_q[2:0]) | bad_aspect(lamps_a_q[5:3])
                           | bad_aspect(lamps_b_q[2:0]) | bad_aspect(lamps_b_q[5:3]);
        // A walk lamp conflicts with the crossing approach, not its own.
        cond[PED_CONFLICT] = (walk_a_q[0] & moving(lamps_a_q[5:3]))
                           | (walk_a_q[1] & moving(lamps_a_q[2:0]))
                           | (walk_b_q[0] & moving(lamps_b_q[5:3]))
                           | (walk_b_q[1] & moving(lamps_b_q[2:0]));
    end

    assign cond_any   = |cond;
    assign clear_rise = fault_clear & ~fault_clear_q;

    cycle_filter #(.N(FILTER_CYCLES)) u_fault_filter (
        .clk_50_mhz (clk_50_mhz),
        .reset      (reset),
        .clear      (state == ST_FAULT),
        .in         (cond_any & monitor_en),
        .met        (trip)
    );

    cycle_filter #(.N(CLEAR_HOLD)) u_clear_hold (
        .clk_50_mhz (clk_50_mhz),
        .reset      (reset),
        .clear      (state != ST_FAULT),
        .in         (~cond_any),
        .met        (hold_ok)
    );

    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) state <= ST_MONITOR;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_MONITOR: if (cond_any && monitor_en) next_state = trip ? ST_FAULT : ST_FILTER;
            ST_FILTER: begin
                if (!cond_any || !monitor_en) next_state = ST_MONITOR;
                else if (trip)                next_state = ST_FAULT;
            end
            ST_FAULT:   if (clear_rise && hold_ok) next_state = ST_MONITOR;
            default:    next_state = ST_MONITOR;
        endcase
    end

    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            accum      <= '0;
            fault_code <= '0;
            flash_red  <= 1'b0;
            flash_cnt  <= '0;
        end else begin
            if (next_state == ST_FILTER) accum <= (state == ST_FILTER) ? (accum | cond) : cond;
            else                         accum <= '0;

            if (state == ST_FAULT && next_state == ST_FAULT) begin
                fault_code <= fault_code | cond;
                if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                    flash_red <= ~flash_red;
                    flash_cnt <= '0;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end else if (state != ST_FAULT && next_state == ST_FAULT) begin
                fault_code <= accum | cond;
                flash_red  <= 1'b1;
                flash_cnt  <= '0;
            end else begin
                fault_code <= '0;
                flash_red  <= 1'b0;
                flash_cnt  <= '0;
            end
        end
    end

    always_comb begin
        fault     = (state == ST_FAULT);
        state_dbg = state;
    end

endmodule
